// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared constants for the instruction fetch slice:
//   INSTR_W          - instruction word width
//   PC_INCR          - word-aligned sequential PC step
//   RESET_PC_DEFAULT - default first fetch address after reset
// Build option: defining FETCH_IMMFIELD_EN adds the pre-sliced immediate
// field outputs on instr_fetch. It is left undefined in the default build.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry {pc, instr} buffer between instruction memory and decode.
// Ports:
//   clk, rstn               - clock, asynchronous active-low reset
//   flush                   - drop all entries (wins over push and pop)
//   push, push_pc, push_instr - write one entry
//   pop                     - consume the head entry
//   full, empty, count      - occupancy status
//   head_pc, head_instr     - head entry (reads 0 while in reset)
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 push,
    input  logic [31:0]          push_pc,
    input  logic [INSTR_W-1:0]   push_instr,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]          head_pc,
    output logic [INSTR_W-1:0]   head_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]        pc_q    [DEPTH];
    logic [31:0]        pc_d    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [INSTR_W-1:0] instr_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push_s;
    logic               do_pop_s;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == {CW{1'b0}});
    assign count      = count_q;
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_instr = instr_q[rd_ptr_q];

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_pop_s  = pop & ~empty & ~flush;
    assign do_push_s = push & ~flush & (~full | do_pop_s);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                pc_d[wr_ptr_q]    = push_pc;
                instr_d[wr_ptr_q] = push_instr;
                wr_ptr_d          = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= 32'h0;
                instr_q[i] <= {INSTR_W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Sequential instruction fetch with redirect handling and a DEPTH-entry
// {pc, instr} buffer feeding decode.
// Ports:
//   clk, rstn                         - clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt       - request channel to instruction memory
//   imem_rvalid/imem_rdata            - in-order response channel
//   redirect_valid/redirect_pc        - branch/jump/trap redirect
//   id_valid/id_ready/id_instr/id_pc  - handshake to decode
// Parameters: RESET_PC (first fetch address), DEPTH (buffer entries, power of 2, >= 2).
// Build option: FETCH_IMMFIELD_EN adds id_iimm, id_simm, id_bimm, id_uimm,
// id_jimm and id_shamt, sliced from id_instr in RISC-V bit order.
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rstn,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc
`ifdef FETCH_IMMFIELD_EN
    ,
    output logic [11:0]        id_iimm,
    output logic [11:0]        id_simm,
    output logic [11:0]        id_bimm,
    output logic [19:0]        id_uimm,
    output logic [19:0]        id_jimm,
    output logic [4:0]         id_shamt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Physical outstanding count also covers responses already marked for drop.
    localparam int OW = $clog2(DEPTH) + 2;
    localparam logic [OW-1:0] CREDITS = OW'(DEPTH);
    localparam logic [OW-1:0] OUT_MAX = OW'(2 * DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;     // pc of the oldest response that will be kept
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_q, drop_d;
    logic          run_q, run_d;             // low in reset, high from the first edge after release

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic          pop_s;
    logic          fire_s;
    logic          req_s;
    logic          rsp_keep_s;
    logic          rsp_drop_s;
    logic [OW-1:0] live_s;
    logic [OW-1:0] occ_s;
    logic [31:0]   redirect_aligned_s;
    logic          unused_s;

    assign redirect_aligned_s = {redirect_pc[31:2], 2'b00};
    assign unused_s           = ^{redirect_pc[1:0], fifo_full_s};

    assign pop_s      = ~fifo_empty_s & id_ready;
    assign rsp_keep_s = imem_rvalid & (drop_q == {OW{1'b0}});
    assign rsp_drop_s = imem_rvalid & (drop_q != {OW{1'b0}});

    // Credit check: entries that will hold data after this cycle's pop, plus
    // responses still to be kept. Counting the pop lets a draining buffer
    // sustain one request per cycle; dropped responses never occupy an entry.
    assign live_s = outstanding_q - drop_q;
    assign occ_s  = OW'(fifo_count_s) - OW'(pop_s) + live_s;
    assign req_s  = run_q & ~redirect_valid & (occ_s < CREDITS) & (outstanding_q < OUT_MAX);
    assign fire_s = req_s & imem_gnt;

    assign imem_req  = req_s;
    assign imem_addr = run_q ? fetch_pc_q : 32'h0;
    assign id_valid  = ~fifo_empty_s;

    // Next-state for PC, response PC, credit and drop counters.
    always_comb begin
        run_d         = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + OW'(fire_s) - OW'(imem_rvalid);
        if (redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_aligned_s;
            resp_pc_d  = redirect_aligned_s;
            drop_d     = outstanding_d;
        end else begin
            if (fire_s) begin
                fetch_pc_d = fetch_pc_q + PC_INCR;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_keep_s) begin
                resp_pc_d = resp_pc_q + PC_INCR;
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (rsp_drop_s) begin
                drop_d = drop_q - OW'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Fetch-control registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= {OW{1'b0}};
            drop_q        <= {OW{1'b0}};
        end else begin
            run_q         <= run_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (redirect_valid),
        .push       (rsp_keep_s),
        .push_pc    (resp_pc_q),
        .push_instr (imem_rdata),
        .pop        (pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s),
        .head_pc    (id_pc),
        .head_instr (id_instr)
    );

`ifdef FETCH_IMMFIELD_EN
    // Raw immediate fields in RISC-V encoding order, ready for the extender.
    assign id_iimm  = id_instr[31:20];
    assign id_simm  = {id_instr[31:25], id_instr[11:7]};
    assign id_bimm  = {id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8]};
    assign id_uimm  = id_instr[31:12];
    assign id_jimm  = {id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21]};
    assign id_shamt = id_instr[24:20];
`endif

endmodule
